// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Even parity of v when odd = 0, odd parity when odd = 1.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] v, input logic odd);
    return (^v) ^ odd;
  endfunction

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_freq / (baud * os);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, re-phased by clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote, error flags and a
// one-entry valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_VOTE = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DATA_DONE = BW'(DATA_BITS);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_t state, state_next;

  logic                     rx_m, rx_s, rx_s_q;
  logic                     tick;
  logic [TW-1:0]            tcnt;
  logic [BW-1:0]            bcnt;
  logic                     s0, s1;
  logic [DATA_BITS-1:0]     shreg;
  logic                     perr, ferr;
  logic                     commit_pend;

  logic                     start_edge, in_frame, vote, vote_ev, bit_end;
  logic                     ferr_next, stop_done, par_exp;
  logic [MAX_DATA_BITS-1:0] data_ext;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(start_edge),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_q <= rx_s;
    end
  end

  always_comb begin
    start_edge = (state == IDLE) && rx_s_q && !rx_s;
    in_frame   = state inside {START, DATA, PARITY, STOP};
    // Third sample is taken live at the vote tick rather than registered.
    vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    vote_ev    = in_frame && tick && (tcnt == T_VOTE);
    bit_end    = in_frame && tick && (tcnt == T_LAST);
    ferr_next  = ferr | ~vote;
    stop_done  = vote_ev && (state == STOP) && (bcnt == B_STOP_LAST);
    data_ext   = '0;
    data_ext[DATA_BITS-1:0] = shreg;
    par_exp    = calc_parity(data_ext, PARITY_ODD != 0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start_edge) state_next = START;
      START: begin
        if (vote_ev && vote) state_next = IDLE;
        else if (bit_end)    state_next = DATA;
      end
      DATA:      if (bit_end && bcnt == B_DATA_DONE) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (bit_end) state_next = STOP;
      STOP:      if (stop_done) state_next = ferr_next ? WAIT_IDLE : IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt        <= '0;
      bcnt        <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      shreg       <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= stop_done;

      if (!in_frame) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
        if (tcnt == T_S0) s0 <= rx_s;
        if (tcnt == T_S1) s1 <= rx_s;
      end

      if (state != state_next) begin
        bcnt <= '0;
      end else if (vote_ev && (state == DATA || state == STOP)) begin
        bcnt <= bcnt + BW'(1);
      end

      if (start_edge) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end else if (vote_ev) begin
        case (state)
          DATA:    shreg <= {vote, shreg[DATA_BITS-1:1]};
          PARITY:  perr  <= (vote != par_exp);
          STOP:    ferr  <= ferr_next;
          default: ;
        endcase
      end
    end
  end

  // Commit happens one cycle after the last stop vote, when ferr/perr are settled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_pend) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ferr;
          parity_err <= perr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_p = 1'b1;
  logic rdy_a = 1'b1, rdy_p = 1'b1;
  logic [7:0] data_a, data_p;
  logic vld_a, vld_p, fe_a, fe_p, pe_a, pe_p, ovr_a, ovr_p, busy_a, busy_p;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(vld_a),
    .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rx_data(data_p), .rx_valid(vld_p),
    .rx_ready(rdy_p), .frame_err(fe_p), .parity_err(pe_p), .overrun(ovr_p), .busy(busy_p)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];
  exp_t e_a, e_p;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_valid_a = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_p = 0;
  logic vld_a_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ovr_a) ovr_cnt_a++;
      if (vld_a && !vld_a_q) first_valid_a = cyc;
      vld_a_q = vld_a;
      if (vld_a && rdy_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_word", {24'd0, data_a}, 32'hFFFF_FFFF);
        end else begin
          e_a = q_a.pop_front();
          check("a_rx_data", {24'd0, data_a}, {24'd0, e_a.d});
          check("a_frame_err", {31'd0, fe_a}, {31'd0, e_a.fe});
          check("a_parity_err", {31'd0, pe_a}, {31'd0, e_a.pe});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ovr_p) ovr_cnt_p++;
      if (vld_p && rdy_p) begin
        if (q_p.size() == 0) begin
          check("p_unexpected_word", {24'd0, data_p}, 32'hFFFF_FFFF);
        end else begin
          e_p = q_p.pop_front();
          check("p_rx_data", {24'd0, data_p}, {24'd0, e_p.d});
          check("p_frame_err", {31'd0, fe_p}, {31'd0, e_p.fe});
          check("p_parity_err", {31'd0, pe_p}, {31'd0, e_p.pe});
        end
      end
    end
  end

  task automatic drive(input bit sel, input logic b, input int n);
    if (sel) rx_p = b;
    else     rx_a = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en, input logic par_bit);
    if (!sel) start_cyc = cyc;
    drive(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
    if (par_en) drive(sel, par_bit, 16);
    drive(sel, 1'b1, 16);
  endtask

  task automatic push_a(input logic [7:0] d, input logic fe, input logic pe);
    exp_t x;
    x.d = d; x.fe = fe; x.pe = pe;
    q_a.push_back(x);
  endtask

  task automatic push_p(input logic [7:0] d, input logic fe, input logic pe);
    exp_t x;
    x.d = d; x.fe = fe; x.pe = pe;
    q_p.push_back(x);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", {31'd0, vld_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_rx_data", {24'd0, data_a}, 32'd0);
    check("reset_overrun", {31'd0, ovr_a}, 32'd0);
    check("reset_parity_err", {31'd0, pe_p}, 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b1, 4);

    // 8N1 0xA5; rising edge of rx_valid lands 158 clocks after the start bit is driven
    push_a(8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 0, 1'b0);
    drive(0, 1'b1, 8);
    check("a_commit_latency", first_valid_a - start_cyc, 32'd158);

    // even parity: 0x37 has five ones, so the correct parity bit is 1
    push_p(8'h37, 1'b0, 1'b0);
    send_frame(1, 8'h37, 1, 1'b1);
    push_p(8'h37, 1'b0, 1'b1);
    send_frame(1, 8'h37, 1, 1'b0);
    drive(1, 1'b1, 8);

    // start glitch of 4 clocks
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 3);
    check("glitch_busy_rise", {31'd0, busy_a}, 32'd1);
    drive(0, 1'b1, 20);
    check("glitch_busy_fall", {31'd0, busy_a}, 32'd0);
    check("glitch_no_valid", {31'd0, vld_a}, 32'd0);

    // break: 30 bit times low
    push_a(8'h00, 1'b1, 1'b0);
    drive(0, 1'b0, 480);
    check("break_wait_idle_busy", {31'd0, busy_a}, 32'd1);
    drive(0, 1'b1, 32);
    check("break_busy_fall", {31'd0, busy_a}, 32'd0);
    check("break_one_word", q_a.size(), 32'd0);

    // overrun with consumer stalled
    check("overrun_none_yet", ovr_cnt_a, 32'd0);
    rdy_a = 1'b0;
    push_a(8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, 0, 1'b0);
    send_frame(0, 8'h22, 0, 1'b0);
    drive(0, 1'b1, 4);
    check("overrun_held_valid", {31'd0, vld_a}, 32'd1);
    check("overrun_held_data", {24'd0, data_a}, 32'h11);
    check("overrun_pulse_count", ovr_cnt_a, 32'd1);
    rdy_a = 1'b1;
    drive(0, 1'b1, 3);
    check("overrun_valid_fall", {31'd0, vld_a}, 32'd0);
    check("overrun_no_second_word", q_a.size(), 32'd0);

    // reset during data bit 3
    check("pre_reset_data", {24'd0, data_a}, 32'h11);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 56);
    check("pre_reset_busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_busy", {31'd0, busy_a}, 32'd0);
    check("midreset_valid", {31'd0, vld_a}, 32'd0);
    check("midreset_data", {24'd0, data_a}, 32'd0);
    check("midreset_frame_err", {31'd0, fe_a}, 32'd0);
    check("midreset_overrun", {31'd0, ovr_a}, 32'd0);
    drive(0, 1'b1, 32);
    push_a(8'h5A, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 0, 1'b0);
    drive(0, 1'b1, 16);

    check("final_queue_a_empty", q_a.size(), 32'd0);
    check("final_queue_p_empty", q_p.size(), 32'd0);
    check("final_overrun_a", ovr_cnt_a, 32'd1);
    check("final_overrun_p", ovr_cnt_p, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the fixed 8N1 receiver that needs an external bps clock.
- Internal oversampling baud-tick generator; no external bps_start/clk_bps pair.
- Configurable data width, parity and stop bits; 3-sample majority voting.
- Framing, parity and overrun detection.
- Delivers each word through a one-entry valid/ready holding register to downstream logic.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame, range 5..9
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0
STOP_BITS, 1, stop bits checked, 1 or 2
OVERSAMPLE, 16, ticks per bit, even number >= 8

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, LSB = first bit on the line
rx_valid  output  1  rx_data and the flags are valid; held until accepted
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready
frame_err  output  1  stop bit(s) sampled low; qualified by rx_valid
parity_err  output  1  parity mismatch; qualified by rx_valid; 0 if PARITY_EN = 0
overrun  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. When rst_n = 0 at an edge:
  - rx_data = 0; rx_valid, frame_err, parity_err, overrun, busy = 0.
  - Synchroniser flops = 1; state = IDLE; all counters = 0.
  - Reset mid-frame aborts the frame silently.
- Input synchroniser: rx passes through 2 flops (rx_s). All logic uses rx_s.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, minimum 1. A one-cycle tick fires every DIV clocks. The counter is cleared on start-edge detection so ticks are phase-aligned to the edge.
- Sampling: within each bit, a tick counter runs 0..OVERSAMPLE-1. rx_s is captured at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 samples and is decided at tick M+1.
- FSM:
  - IDLE: rx_s 1->0 edge -> START, busy = 1.
  - START: voted bit 1 -> IDLE (false start; nothing output). Voted bit 0 -> DATA at the end of the bit period.
  - DATA: shift in DATA_BITS bits, LSB first. Then -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: compare the voted bit with the XOR of the data bits, inverted if PARITY_ODD. Mismatch sets internal perr. -> STOP.
  - STOP: check STOP_BITS bits. Any voted 0 sets internal ferr. After the last stop bit's vote:
    - if ferr = 0 -> IDLE;
    - if ferr = 1 (break or framing loss) -> WAIT_IDLE.
  - WAIT_IDLE: stays until rx_s = 1, then -> IDLE.
- Commit: in the clock cycle after the last stop bit's vote tick, the word is committed.
  - If the holding register is empty, or rx_valid & rx_ready in that same cycle: load rx_data, frame_err and parity_err, and set rx_valid = 1.
  - Otherwise drop the new word, pulse overrun for 1 cycle, and leave the held word unchanged.
- A word is delivered even when it carries errors; the flags describe it.
- Handshake: rx_valid falls in the cycle after rx_valid & rx_ready, unless a commit reloads it in that same cycle. rx_data and the flags are stable while rx_valid = 1 and not accepted.
- busy falls on the transition to IDLE. A new start edge is accepted in the cycle after IDLE is entered; there is no stop-bit-end dead time beyond the vote point.
- Width rule: the frame bit counter is $clog2(DATA_BITS+1) bits wide; the tick counter is $clog2(OVERSAMPLE) bits wide.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - function for parity over a vector;
  - constant helper for computing DIV.
- One sub-module, uart_baud_tick: parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, rst_n, clear, tick.
- Majority vote, FSM and output register stay in uart_rx_param.

Test Plan:
All scenarios use CLK_FREQ = 1600000, BAUD = 100000, OVERSAMPLE = 16, giving DIV = 1 and 16 clocks per bit.
- 8N1, send 0xA5, rx_ready = 1: rx_valid pulses 1 cycle, rx_data = 0xA5, frame_err = 0, parity_err = 0; commit 1 clk after the stop-bit vote.
- PARITY_EN = 1, PARITY_ODD = 0:
  - send 0x37 with parity 1 -> parity_err = 0;
  - send 0x37 with parity 0 -> parity_err = 1, rx_data = 0x37.
- Start glitch: rx low for 4 clocks, then high -> returns to IDLE, busy drops, rx_valid stays 0.
- Break: rx held low for 30 bit times, then high -> one word rx_data = 0x00 with frame_err = 1; no further word until rx has been high and a new start edge occurs.
- Overrun: rx_ready = 0, send 0x11 then 0x22 -> rx_valid = 1, rx_data = 0x11, and overrun pulses once at the second commit. Then raise rx_ready -> rx_valid falls, with no 0x22 delivered.
- Reset mid-frame: assert rst_n = 0 for 1 clk during DATA bit 3 -> all outputs 0 next edge. A following 0x5A frame is received correctly.
